sensor_scan_ctrl: RTL and testbench
===================================

# sensor_scan_ctrl

Sequencer that scans the four baggage-height sensors through one shared conversion channel and produces a registered height. On `start` it selects each sensor in turn (1→4), waits a settle time, issues a conversion request, and captures the result or a timeout. It then computes the height with the drop-station fusion rule and pulses `height_valid`. It sits between the shared sensor front-end and the baggage-drop FSM, which consumes `height` and `fault_mask`.

## Interface
- `SETTLE_CYCLES`, default 2: cycles `sel` is held stable before `conv_req`; legal range 1..15.
- `TIMEOUT_CYCLES`, default 16: WAIT cycles allowed for `conv_done` before the sensor is declared faulty; legal range 1..255.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  frame request; sampled only in IDLE.
- `sel`  out  2  shared-channel sensor select: 0..3 = sensor1..sensor4.
- `conv_req`  out  1  one-cycle conversion request.
- `conv_done`  in  1  conversion complete, qualifies `conv_data`.
- `conv_data`  in  8  conversion result.
- `sensor1`..`sensor4`  out  8 each  captured readings, registered.
- `fault_mask`  out  4  bit i set = sensor i+1 timed out during this frame.
- `height`  out  8  fused height, registered.
- `height_valid`  out  1  one-cycle pulse, height updated.
- `busy`  out  1  high in every non-IDLE state.

## Operation
- States: IDLE, SETTLE, REQ, WAIT, CALC.
- IDLE: `sel`=0, `busy`=0. If `start`=1 → SETTLE, idx←0, `fault_mask`←0, settle counter←0.
- SETTLE: `sel`=idx. Stays for exactly SETTLE_CYCLES cycles → REQ.
- REQ: `conv_req`=1 for this single cycle; `conv_done` ignored here. → WAIT, timeout counter←0.
- WAIT: `conv_req`=0.
  - If `conv_done`=1: capture `conv_data` into sensor[idx].
  - Else if the counter reaches TIMEOUT_CYCLES WAIT cycles: capture 0 into sensor[idx] and set `fault_mask[idx]`.
  - After a capture, idx=3 → CALC; otherwise idx+1 → SETTLE.
- CALC: one cycle. `height` is registered at the end of the cycle. → IDLE with `height_valid`=1 for the first IDLE cycle.
- Fusion rule, using 10-bit intermediate sums and truncating division:
  - If s1=0 or s3=0: (s2+s4+1)/2.
  - Else if s2=0 or s4=0: (s1+s3+1)/2.
  - Else: (s1+s2+s3+s4+2)/4.
  - A zero reading, whether measured or from a timeout, counts as a dead sensor.
- `sensor1`..`sensor4` and `height` hold their values between frames; only captures and CALC change them.
- `start` while busy is ignored; it is not queued.
- `conv_done` outside WAIT is ignored.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. Takes effect immediately and asynchronously, including mid-frame. `conv_req` drops at once, and no `height_valid` is produced for the aborted frame.
- Per-sensor cycles = SETTLE_CYCLES + 1 (REQ) + k, where k is the WAIT cycle in which `conv_done` is seen (1..TIMEOUT_CYCLES). A timeout gives k = TIMEOUT_CYCLES.
- Example, defaults with k=1 on all sensors (`start` sampled at edge 0):
  - Sensor 1: SETTLE cycles 1–2, REQ cycle 3, WAIT cycle 4. Sensors 2–4 follow in cycles 5–16.
  - CALC in cycle 17; `height_valid` in cycle 18.
  - `busy` is high in cycles 1–17.
  - A `start` in cycle 18 is accepted.
- Back-to-back frames: `height_valid` and new-frame acceptance coincide in the same IDLE cycle.
- `conv_done` in the same cycle as timeout expiry: the data capture wins, and no fault bit is set.
- `sel` changes only on entry to SETTLE and on return to IDLE, never during REQ or WAIT.

## Test plan
- Normal frame, defaults: readings 100,102,98,100, `conv_done` 1 cycle after each `conv_req` → `height`=100, `fault_mask`=0000, `height_valid` exactly in cycle 18, four `conv_req` pulses with `sel` = 0,1,2,3.
- Sensor 3 never answers: readings 80,82,–,84 → 16-cycle timeout on sensor 3, sensor3=0, `fault_mask`=0100, `height`=(82+84+1)/2=83.
- Rounding and width: all readings 255 → `height`=255 with no overflow. Readings 1,2,2,2 → (7+2)/4=2.
- `start` held high throughout, with a 3-cycle conversion delay → consecutive frames with no gap. The second frame's `fault_mask` is cleared at its start. `conv_done` pulses injected in SETTLE and REQ are ignored.
- `rst` asserted in the WAIT state of sensor 2 → all outputs 0 immediately and no `height_valid`. A new `start` yields a full four-sensor frame.
- `conv_done` on the exact timeout cycle, value 50 → captured as 50, fault bit clear.

Source files
------------

// File: rtl/sensor_scan_ctrl.sv
// sensor_scan_ctrl
// Scans the four baggage-height sensors through one shared conversion
// channel, captures each reading (or 0 on timeout), then fuses the four
// readings into a single registered height.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               frame request, only honoured while idle
//   sel                 shared-channel sensor select (0..3)
//   conv_req            one-cycle conversion request
//   conv_done/conv_data conversion handshake from the front-end
//   sensor1..sensor4    captured readings, held between frames
//   fault_mask          bit i set when sensor i+1 timed out this frame
//   height/height_valid fused height and its one-cycle update strobe
//   busy                high whenever a frame is in progress
module sensor_scan_ctrl #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] sel,
    output logic       conv_req,
    input  logic       conv_done,
    input  logic [7:0] conv_data,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    output logic [3:0] fault_mask,
    output logic [7:0] height,
    output logic       height_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        REQ,
        WAIT,
        CALC
    } state_t;

    // Counters run from 0, so the terminal value is one less than the count.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [3:0]  settle_cnt;
    logic [7:0]  wait_cnt;
    logic [7:0]  readings [4];
    logic        capture;
    logic        capture_fault;
    logic [7:0]  capture_value;
    logic [7:0]  fused_height;

    assign sensor1 = readings[0];
    assign sensor2 = readings[1];
    assign sensor3 = readings[2];
    assign sensor4 = readings[3];

    // A zero reading marks a dead sensor; fall back to the opposite pair
    // when either member of a pair is dead, otherwise average all four.
    function automatic logic [7:0] fuse(input logic [7:0] s1, input logic [7:0] s2,
                                        input logic [7:0] s3, input logic [7:0] s4);
        logic [9:0] sum;
        if (s1 == 8'd0 || s3 == 8'd0) begin
            sum = 10'(s2) + 10'(s4) + 10'd1;
            return 8'(sum >> 1);
        end else if (s2 == 8'd0 || s4 == 8'd0) begin
            sum = 10'(s1) + 10'(s3) + 10'd1;
            return 8'(sum >> 1);
        end else begin
            sum = 10'(s1) + 10'(s2) + 10'(s3) + 10'(s4) + 10'd2;
            return 8'(sum >> 2);
        end
    endfunction

    assign fused_height = fuse(readings[0], readings[1], readings[2], readings[3]);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and outputs. sel and conv_req are decoded from state so a
    // reset drops them immediately. conv_done is only looked at in WAIT,
    // and data beats the timeout when both land in the same cycle.
    always_comb begin
        state_next    = state;
        sel           = idx;
        conv_req      = 1'b0;
        busy          = 1'b1;
        capture       = 1'b0;
        capture_fault = 1'b0;
        capture_value = 8'd0;
        case (state)
            IDLE: begin
                sel  = 2'd0;
                busy = 1'b0;
                if (start) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                conv_req   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (conv_done) begin
                    capture       = 1'b1;
                    capture_value = conv_data;
                end else if (wait_cnt == WAIT_LAST) begin
                    capture       = 1'b1;
                    capture_fault = 1'b1;
                end
                if (capture) begin
                    state_next = (idx == 2'd3) ? CALC : SETTLE;
                end
            end
            CALC: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // Datapath: counters, sensor index, captures and the fused result.
    // idx stays at 3 through CALC so sel only moves back to 0 in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= 2'd0;
            settle_cnt   <= 4'd0;
            wait_cnt     <= 8'd0;
            fault_mask   <= 4'd0;
            height       <= 8'd0;
            height_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                readings[i] <= 8'd0;
            end
        end else begin
            height_valid <= (state == CALC);
            case (state)
                IDLE: begin
                    if (start) begin
                        idx        <= 2'd0;
                        settle_cnt <= 4'd0;
                        fault_mask <= 4'd0;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                REQ: begin
                    wait_cnt <= 8'd0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (capture) begin
                        readings[idx] <= capture_value;
                        if (capture_fault) begin
                            fault_mask[idx] <= 1'b1;
                        end
                        if (idx != 2'd3) begin
                            idx <= idx + 2'd1;
                        end
                        settle_cnt <= 4'd0;
                    end
                end
                CALC: begin
                    height <= fused_height;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb_sensor_scan_ctrl
// Directed bench for sensor_scan_ctrl. Each frame pushes its expected
// readings, fault mask and fused height onto a scoreboard when it is
// started; the entry is popped and compared when height_valid appears.
// Stimulus is driven and outputs sampled on the falling clock edge.
module tb_sensor_scan_ctrl;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic       conv_req;
    logic       conv_done;
    logic [7:0] conv_data;
    logic [7:0] sensor1;
    logic [7:0] sensor2;
    logic [7:0] sensor3;
    logic [7:0] sensor4;
    logic [3:0] fault_mask;
    logic [7:0] height;
    logic       height_valid;
    logic       busy;

    typedef struct packed {
        logic [7:0]      height;
        logic [3:0]      fault;
        logic [3:0][7:0] s;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    sensor_scan_ctrl #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sel          (sel),
        .conv_req     (conv_req),
        .conv_done    (conv_done),
        .conv_data    (conv_data),
        .sensor1      (sensor1),
        .sensor2      (sensor2),
        .sensor3      (sensor3),
        .sensor4      (sensor4),
        .fault_mask   (fault_mask),
        .height       (height),
        .height_valid (height_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference fusion rule written straight from the integer definition.
    function automatic int exp_fuse(input int a, input int b, input int c, input int d);
        if (a == 0 || c == 0) return (b + d + 1) / 2;
        if (b == 0 || d == 0) return (a + c + 1) / 2;
        return (a + b + c + d + 2) / 4;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one frame from an IDLE falling edge to the falling edge of the
    // height_valid cycle. kv[i] is the WAIT cycle in which sensor i answers;
    // 0 means it never answers. noise injects stray conv_done pulses in
    // the first SETTLE cycle and in every REQ cycle.
    task automatic apply_stimulus(input logic [3:0][7:0] data, input logic [3:0][7:0] kv,
                                  input bit keep_start, input bit noise);
        exp_t e;
        exp_t got;
        int   hv_exp;
        int   cyc;
        int   reqs;
        int   ridx;
        int   resp_cyc;
        bit   pend;
        hv_exp = 2;
        for (int i = 0; i < 4; i++) begin
            e.s[i]     = (kv[i] == 8'd0) ? 8'd0 : data[i];
            e.fault[i] = (kv[i] == 8'd0);
            hv_exp += SETTLE + 1 + ((kv[i] == 8'd0) ? TIMEOUT : int'(kv[i]));
        end
        e.height = 8'(exp_fuse(int'(e.s[0]), int'(e.s[1]), int'(e.s[2]), int'(e.s[3])));
        sb.push_back(e);

        start = 1'b1;
        @(negedge clk);
        cyc = 1;
        if (!keep_start) start = 1'b0;
        reqs     = 0;
        ridx     = 0;
        resp_cyc = 0;
        pend     = 1'b0;
        check_output("fault_clear_at_start", 32'(fault_mask), 32'd0);
        while (1) begin
            check_output($sformatf("busy_c%0d", cyc), 32'(busy), 32'(cyc < hv_exp));
            check_output($sformatf("hv_c%0d", cyc), 32'(height_valid), 32'(cyc == hv_exp));
            if (cyc == hv_exp) break;
            conv_done = 1'b0;
            conv_data = 8'hEE;
            if (pend && cyc == resp_cyc) begin
                conv_done = 1'b1;
                conv_data = data[ridx];
                pend      = 1'b0;
            end
            if (conv_req === 1'b1) begin
                check_output($sformatf("req_sel_%0d", reqs), 32'(sel), 32'(reqs));
                if (reqs < 4) begin
                    ridx = reqs;
                    if (kv[ridx] != 8'd0) begin
                        pend     = 1'b1;
                        resp_cyc = cyc + int'(kv[ridx]);
                    end
                end
                reqs++;
                if (noise) begin
                    conv_done = 1'b1;
                    conv_data = 8'hA5;
                end
            end
            if (noise && cyc == 1) begin
                conv_done = 1'b1;
                conv_data = 8'hDD;
            end
            @(negedge clk);
            cyc++;
        end
        conv_done = 1'b0;
        check_output("req_count", 32'(reqs), 32'd4);
        check_output("sel_idle", 32'(sel), 32'd0);
        got = sb.pop_front();
        check_output("height", 32'(height), 32'(got.height));
        check_output("fault_mask", 32'(fault_mask), 32'(got.fault));
        check_output("sensor1", 32'(sensor1), 32'(got.s[0]));
        check_output("sensor2", 32'(sensor2), 32'(got.s[1]));
        check_output("sensor3", 32'(sensor3), 32'(got.s[2]));
        check_output("sensor4", 32'(sensor4), 32'(got.s[3]));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_sel"}, 32'(sel), 32'd0);
        check_output({tag, "_conv_req"}, 32'(conv_req), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_hv"}, 32'(height_valid), 32'd0);
        check_output({tag, "_height"}, 32'(height), 32'd0);
        check_output({tag, "_fault"}, 32'(fault_mask), 32'd0);
        check_output({tag, "_s1"}, 32'(sensor1), 32'd0);
        check_output({tag, "_s2"}, 32'(sensor2), 32'd0);
        check_output({tag, "_s3"}, 32'(sensor3), 32'd0);
        check_output({tag, "_s4"}, 32'(sensor4), 32'd0);
    endtask

    initial begin
        int  reqs;
        int  n;
        bit  respond;

        rst       = 1'b1;
        start     = 1'b0;
        conv_done = 1'b0;
        conv_data = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] normal frame");
        apply_stimulus({8'd100, 8'd98, 8'd102, 8'd100}, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 1'b0);

        $display("[TB] sensor 3 silent, start accepted in the height_valid cycle");
        apply_stimulus({8'd84, 8'd0, 8'd82, 8'd80}, {8'd1, 8'd0, 8'd1, 8'd1}, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        $display("[TB] full-scale readings");
        apply_stimulus({8'd255, 8'd255, 8'd255, 8'd255}, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] rounding 1,2,2,2");
        apply_stimulus({8'd2, 8'd2, 8'd2, 8'd1}, {8'd2, 8'd1, 8'd3, 8'd1}, 1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] back-to-back frames with stray conv_done");
        apply_stimulus({8'd80, 8'd70, 8'd60, 8'd0}, {8'd3, 8'd3, 8'd3, 8'd0}, 1'b1, 1'b1);
        apply_stimulus({8'd40, 8'd30, 8'd20, 8'd10}, {8'd3, 8'd3, 8'd3, 8'd3}, 1'b1, 1'b1);
        start = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] reset during WAIT of sensor 2");
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        reqs    = 0;
        n       = 0;
        respond = 1'b0;
        while (reqs < 2 && n < 60) begin
            conv_done = respond;
            conv_data = 8'd33;
            respond   = 1'b0;
            if (conv_req === 1'b1) begin
                reqs++;
                if (reqs == 1) respond = 1'b1;
            end
            if (reqs < 2) begin
                @(negedge clk);
                n++;
            end
        end
        conv_done = 1'b0;
        check_output("abort_reached_req2", 32'(reqs), 32'd2);
        @(negedge clk);
        @(negedge clk);
        check_output("abort_sel_before", 32'(sel), 32'd1);
        check_output("abort_s1_before", 32'(sensor1), 32'd33);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_output($sformatf("abort_no_hv_%0d", i), 32'(height_valid), 32'd0);
        end

        $display("[TB] full frame after abort, measured zero on sensor 2");
        apply_stimulus({8'd9, 8'd7, 8'd0, 8'd5}, {8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 1'b0);
        @(negedge clk);

        $display("[TB] conv_done on the timeout cycle");
        apply_stimulus({8'd50, 8'd40, 8'd40, 8'd40}, {8'd16, 8'd1, 8'd1, 8'd1}, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
